// File: rtl/hl2_ds_pkg.sv
// Shared types and constants for the downstream I/Q packer.
// DS_IQ_PACKER_CW_EN widens the sample entry with the two CW key bits.
// Entry layout is {i, q, ptt[, cw]} in both builds.
package hl2_ds_pkg;

  localparam int CNT_W = 16;

  // Byte position within a 4-byte I/Q beat group.
  localparam logic [1:0] BEAT_I_HI = 2'd0;
  localparam logic [1:0] BEAT_I_LO = 2'd1;
  localparam logic [1:0] BEAT_Q_HI = 2'd2;
  localparam logic [1:0] BEAT_Q_LO = 2'd3;

  // Output FSM states.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FILL = 2'd1;
  localparam state_t ST_RUN  = 2'd2;

  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
    logic        ptt;
`ifdef DS_IQ_PACKER_CW_EN
    logic [1:0]  cw;
`endif
  } sample_t;

  localparam int ENTRY_W = $bits(sample_t);

  // Increment by one when enabled, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ds_iq_fifo.sv
// Single-clock FIFO with occupancy level, simultaneous read/write and sync clear.
// Latency: write visible in level next cycle; rd_dat is the head entry, combinational.
// Backpressure: writes are dropped when full unless a read succeeds the same cycle.
module ds_iq_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 33,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_vld,
  input  logic [W-1:0]  wr_dat,
  input  logic          rd_rdy,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          wr_go, rd_go;

  assign full   = (cnt_q == LW'(DEPTH));
  assign empty  = (cnt_q == '0);
  assign level  = cnt_q;
  assign rd_dat = mem_q[rd_ptr_q];

  // A pop frees the slot this cycle, so a write into a full FIFO still lands.
  assign rd_go = rd_rdy && !empty && !clr;
  assign wr_go = wr_vld && (!full || rd_go) && !clr;

  // Next-state for pointers and occupancy; clear wins over everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (wr_go) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_go) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr_go && !rd_go)      cnt_d = cnt_q + 1'b1;
      else if (rd_go && !wr_go) cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (wr_go) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/ds_iq_packer.sv
// Packs the downstream I/Q byte stream into samples and releases one per DUC strobe.
// Latency: level +1 the cycle after beat 3; out_valid/data one cycle after sample_stb.
// Backpressure: none; bytes are always taken, a full FIFO drops and counts the entry.
// DS_IQ_PACKER_CW_EN: store and output the CW key bits (otherwise out_cw is 2'b00).
module ds_iq_packer
  import hl2_ds_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int PREFILL = 32,
  localparam int LW     = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ds_tdata,
  input  logic             ds_tvalid,
  input  logic             ds_tlast,
  input  logic             ds_tuser,
  input  logic             flush,
  input  logic             sample_stb,
  output logic             out_valid,
  output logic [15:0]      out_i,
  output logic [15:0]      out_q,
  output logic             out_ptt,
  output logic [1:0]       out_cw,
  output logic [LW-1:0]    level,
  output logic [CNT_W-1:0] underflow_cnt,
  output logic [CNT_W-1:0] overflow_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  logic [1:0]       beat_q, beat_d;
  logic [23:0]      asm_q, asm_d;
  logic             ptt_q, ptt_d;
`ifdef DS_IQ_PACKER_CW_EN
  logic [1:0]       cw_q, cw_d;
`endif
  state_t           state_q, state_d;
  sample_t          smp_out_q, smp_out_d;
  logic             out_vld_q, out_vld_d;
  logic [CNT_W-1:0] uf_cnt_q, uf_cnt_d;
  logic [CNT_W-1:0] of_cnt_q, of_cnt_d;
  logic [CNT_W-1:0] fe_cnt_q, fe_cnt_d;

  sample_t          wr_entry;
  sample_t          rd_entry;
  logic             wr_req, frame_err;
  logic             pop_req, pop_ok, underflow_ev, overflow_ev;
  logic             fifo_full, fifo_empty;
  logic [LW-1:0]    fifo_level;

  // Byte assembly: shift bytes in, capture sideband per beat, judge framing on tlast/beat 3.
  always_comb begin
    beat_d    = beat_q;
    asm_d     = asm_q;
    ptt_d     = ptt_q;
`ifdef DS_IQ_PACKER_CW_EN
    cw_d      = cw_q;
`endif
    wr_req    = 1'b0;
    frame_err = 1'b0;
    if (flush) begin
      beat_d = BEAT_I_HI;
    end else if (ds_tvalid) begin
      asm_d = {asm_q[15:0], ds_tdata};
      case (beat_q)
        BEAT_I_HI: ptt_d = ds_tuser;
`ifdef DS_IQ_PACKER_CW_EN
        BEAT_I_LO: cw_d[0] = ds_tuser;
        BEAT_Q_HI: cw_d[1] = ds_tuser;
`endif
        default: ;
      endcase
      if (beat_q == BEAT_Q_LO) begin
        beat_d    = BEAT_I_HI;
        wr_req    = ds_tlast;
        frame_err = !ds_tlast;
      end else if (ds_tlast) begin
        beat_d    = BEAT_I_HI;
        frame_err = 1'b1;
      end else begin
        beat_d = beat_q + 2'd1;
      end
    end
  end

  // Entry presented to the FIFO on the closing byte; the last byte comes straight off the bus.
  always_comb begin
    wr_entry     = '0;
    wr_entry.i   = asm_q[23:8];
    wr_entry.q   = {asm_q[7:0], ds_tdata};
    wr_entry.ptt = ptt_q;
`ifdef DS_IQ_PACKER_CW_EN
    wr_entry.cw  = cw_q;
`endif
  end

  // Only RUN consumes entries; a strobe into an empty FIFO there is an underflow.
  assign pop_req      = sample_stb && (state_q == ST_RUN) && !flush;
  assign pop_ok       = pop_req && !fifo_empty;
  assign underflow_ev = pop_req && fifo_empty;
  assign overflow_ev  = wr_req && fifo_full && !pop_ok;

  ds_iq_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .wr_vld (wr_req),
    .wr_dat (wr_entry),
    .rd_rdy (pop_req),
    .rd_dat (rd_entry),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  // Output FSM: IDLE after reset/flush, FILL until prefill is met, RUN until an underflow.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: if (fifo_level >= LW'(PREFILL)) state_d = ST_RUN;
        ST_RUN:  if (underflow_ev) state_d = ST_FILL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Every strobe answers next cycle: popped entry when available, zeros otherwise; held between strobes.
  always_comb begin
    out_vld_d = sample_stb;
    smp_out_d = smp_out_q;
    if (sample_stb) begin
      smp_out_d = pop_ok ? rd_entry : '0;
    end
    uf_cnt_d = sat_inc(uf_cnt_q, underflow_ev);
    of_cnt_d = sat_inc(of_cnt_q, overflow_ev);
    fe_cnt_d = sat_inc(fe_cnt_q, frame_err);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q    <= BEAT_I_HI;
      asm_q     <= '0;
      ptt_q     <= 1'b0;
`ifdef DS_IQ_PACKER_CW_EN
      cw_q      <= 2'b00;
`endif
      state_q   <= ST_IDLE;
      smp_out_q <= '0;
      out_vld_q <= 1'b0;
      uf_cnt_q  <= '0;
      of_cnt_q  <= '0;
      fe_cnt_q  <= '0;
    end else begin
      beat_q    <= beat_d;
      asm_q     <= asm_d;
      ptt_q     <= ptt_d;
`ifdef DS_IQ_PACKER_CW_EN
      cw_q      <= cw_d;
`endif
      state_q   <= state_d;
      smp_out_q <= smp_out_d;
      out_vld_q <= out_vld_d;
      uf_cnt_q  <= uf_cnt_d;
      of_cnt_q  <= of_cnt_d;
      fe_cnt_q  <= fe_cnt_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign out_i         = smp_out_q.i;
  assign out_q         = smp_out_q.q;
  assign out_ptt       = smp_out_q.ptt;
`ifdef DS_IQ_PACKER_CW_EN
  assign out_cw        = smp_out_q.cw;
`else
  assign out_cw        = 2'b00;
`endif
  assign level         = fifo_level;
  assign underflow_cnt = uf_cnt_q;
  assign overflow_cnt  = of_cnt_q;
  assign frame_err_cnt = fe_cnt_q;

endmodule
